// File: rtl/sdram_ch3_wrbuf.sv
// rtl/sdram_ch3_wrbuf.sv - posted-write FIFO and read sequencer for SDRAM channel 3
//
// Purpose: clients post 32-bit writes into a circular FIFO that drains one
// transaction at a time onto the ch3 request/ready handshake. A single read
// is held pending until every previously accepted write has drained, which
// gives read-after-write ordering without any address compare.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   wr_req/addr/data/be  write post; ignored while wr_full
//   wr_full, wr_empty    FIFO full; FIFO empty with no write in flight
//   rd_req/addr          single read request; ignored while rd_busy
//   rd_busy              read pending or in flight
//   rd_data, rd_valid    read result and its one-cycle strobe
//   ram_addr/din/be/rnw  transaction fields toward ch3
//   ram_req              one-cycle pulse, controller acts on its rising edge
//   ram_ready, ram_dout  completion (edge-detected) and read data from ch3

module sdram_ch3_wrbuf #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_req,
    input  logic [26:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic        wr_full,
    output logic        wr_empty,
    input  logic        rd_req,
    input  logic [26:0] rd_addr,
    output logic        rd_busy,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [26:0] ram_addr,
    output logic [31:0] ram_din,
    output logic [3:0]  ram_be,
    output logic        ram_rnw,
    output logic        ram_req,
    input  logic        ram_ready,
    input  logic [31:0] ram_dout
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WWAIT = 2'd1;
    localparam logic [1:0] ST_RWAIT = 2'd2;

    logic [26:0]           fifo_addr [DEPTH];
    logic [31:0]           fifo_data [DEPTH];
    logic [3:0]            fifo_be   [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    logic [1:0]            state;
    logic                  rd_pend;
    logic [26:0]           rd_addr_q;
    logic                  ram_ready_d;

    logic                  push;
    logic                  pop;
    logic                  issue_rd;
    logic                  ready_edge;

    // Full is taken from the registered count only, so a pop in the same
    // cycle never makes room for a push at full.
    assign wr_full    = (count == FULL_COUNT);
    assign push       = wr_req & ~wr_full;
    assign pop        = (state == ST_IDLE) && (count != '0);
    // A push in this cycle must drain before the read, so it blocks issue.
    assign issue_rd   = (state == ST_IDLE) && (count == '0) && rd_pend && !push;
    // Ready may be held for two cycles; only its rising edge completes.
    assign ready_edge = ram_ready & ~ram_ready_d;

    assign rd_busy  = rd_pend | (state == ST_RWAIT);
    assign wr_empty = (count == '0) && (state != ST_WWAIT);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
            fifo_be[wr_ptr]   <= wr_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rd_pend     <= 1'b0;
            rd_addr_q   <= '0;
            ram_ready_d <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= '0;
            ram_be      <= '0;
            ram_rnw     <= 1'b0;
            ram_req     <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
        end else begin
            ram_ready_d <= ram_ready;
            rd_valid    <= 1'b0;
            // Every issue is a single-cycle pulse; the wait states that
            // follow keep it low so the next issue shows a clean edge.
            ram_req     <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase

            if (rd_req && !rd_busy) begin
                rd_pend   <= 1'b1;
                rd_addr_q <= rd_addr;
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        ram_addr <= fifo_addr[rd_ptr];
                        ram_din  <= fifo_data[rd_ptr];
                        ram_be   <= fifo_be[rd_ptr];
                        ram_rnw  <= 1'b0;
                        ram_req  <= 1'b1;
                        state    <= ST_WWAIT;
                    end else if (issue_rd) begin
                        ram_addr <= rd_addr_q;
                        ram_be   <= 4'hF;
                        ram_rnw  <= 1'b1;
                        ram_req  <= 1'b1;
                        state    <= ST_RWAIT;
                    end
                end
                ST_WWAIT: begin
                    if (ready_edge) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RWAIT: begin
                    if (ready_edge) begin
                        rd_data  <= ram_dout;
                        rd_valid <= 1'b1;
                        rd_pend  <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
